bootrom_loader: RTL



---
 rtl/bootrom_loader_pkg.sv | 33 +++
 rtl/bootrom_loader_timeout_cnt.sv | 30 +++
 rtl/bootrom_loader.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bootrom_loader_pkg.sv
// Shared types and constants for the boot ROM in-system loader.
package bootrom_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'h5A;

    // Bits needed to represent v (minimum 1); shared with the boot ROM sizing.
    function automatic int unsigned clogb2(input int unsigned v);
        int unsigned r;
        int unsigned t;
        r = 0;
        t = v;
        while (t > 0) begin
            r = r + 1;
            t = t >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/bootrom_loader_timeout_cnt.sv
// Idle counter: cleared to zero, counts enabled clocks, flags the limit.
module loader_timeout_cnt
    import bootrom_loader_pkg::*;
#(
    parameter int unsigned LIMIT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc_c
);

    localparam int unsigned CW = clogb2(LIMIT);

    logic [CW-1:0] cnt;

    // Terminal count fires on the clock that would bring the count to LIMIT.
    assign tc_c = en && !clr && (cnt == CW'(LIMIT - 1));

    // Count idle clocks; any clear reloads zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !tc_c) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bootrom_loader.sv
// Framed byte-stream programmer driving the boot ROM write port.
module bootrom_loader
    import bootrom_loader_pkg::*;
#(
    parameter int unsigned RAM_DEPTH   = 65536,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
    localparam int unsigned AW         = clogb2(RAM_DEPTH - 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          wen,
    output logic [AW-1:0] waddr,
    output logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code
);

    state_t        state_q, state_d;
    logic [7:0]    len_lo_q, len_lo_d;
    logic [15:0]   len_q, len_d;
    logic [AW-1:0] widx_q, widx_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [23:0]   asm_q, asm_d;
    logic [7:0]    csum_q, csum_d;
    logic          wen_d, busy_d, done_d, err_d;
    logic [AW-1:0] waddr_d;
    logic [31:0]   wdata_d;
    logic [1:0]    code_d;
    logic          acc;
    logic          tmo_tc;
    logic [15:0]   len_rx;

    // The loader sustains one byte per clock, so it never back-pressures.
    assign rx_ready = 1'b1;
    assign acc      = rx_valid;
    assign len_rx   = {rx_data, len_lo_q};

    // Inter-byte idle watchdog; only armed while a frame is open.
    loader_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_tmo (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != ST_IDLE),
        .clr  (acc || (state_q == ST_IDLE)),
        .tc_c (tmo_tc)
    );

    // Frame parser: next state, word assembly, checksum and write strobes.
    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        widx_d   = widx_q;
        bcnt_d   = bcnt_q;
        asm_d    = asm_q;
        csum_d   = csum_q;
        wen_d    = 1'b0;
        waddr_d  = waddr;
        wdata_d  = wdata;
        busy_d   = busy;
        done_d   = 1'b0;
        err_d    = 1'b0;
        code_d   = err_code;

        case (state_q)
            ST_IDLE: begin
                if (acc && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_LEN0;
                    busy_d  = 1'b1;
                    csum_d  = 8'd0;
                    widx_d  = '0;
                    bcnt_d  = 2'd0;
                end
            end
            ST_LEN0: begin
                if (acc) begin
                    len_lo_d = rx_data;
                    state_d  = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (acc) begin
                    len_d = len_rx;
                    if (32'(len_rx) > RAM_DEPTH) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        busy_d  = 1'b0;
                    end else if (len_rx == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (acc) begin
                    csum_d = csum_q + rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    case (bcnt_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        default: begin
                            wen_d   = 1'b1;
                            waddr_d = widx_q;
                            wdata_d = {rx_data, asm_q};
                            widx_d  = widx_q + AW'(1);
                            if ((32'(widx_q) + 32'd1) == 32'(len_q)) begin
                                state_d = ST_CSUM;
                            end
                        end
                    endcase
                end
            end
            ST_CSUM: begin
                if (acc) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (rx_data == csum_q) begin
                        done_d = 1'b1;
                        code_d = ERR_NONE;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_CSUM;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog abort; only possible on a clock with no byte, so no write is pending.
        if (tmo_tc) begin
            state_d = ST_IDLE;
            wen_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
            code_d  = ERR_TMO;
            busy_d  = 1'b0;
        end
    end

    // State and registered outputs; reset cancels any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            len_lo_q <= 8'd0;
            len_q    <= 16'd0;
            widx_q   <= '0;
            bcnt_q   <= 2'd0;
            asm_q    <= 24'd0;
            csum_q   <= 8'd0;
            wen      <= 1'b0;
            waddr    <= '0;
            wdata    <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            widx_q   <= widx_d;
            bcnt_q   <= bcnt_d;
            asm_q    <= asm_d;
            csum_q   <= csum_d;
            wen      <= wen_d;
            waddr    <= waddr_d;
            wdata    <= wdata_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            err_code <= code_d;
        end
    end

endmodule
